// File: rtl/ram_march_bist_if.sv
// Command/data bus between the March BIST initiator and the dual-port register-file RAM.
interface ram_march_bist_if #(
  parameter int DATA_W    = 10,
  parameter int ADDR_SIZE = 6
);
  logic                 write;
  logic [DATA_W-1:0]    datain;
  logic [ADDR_SIZE-1:0] addr_w;
  logic                 read;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [DATA_W-1:0]    dataout;

  modport master (output write, datain, addr_w, read, addr_r, input dataout);
  modport slave  (input write, datain, addr_w, read, addr_r, output dataout);
endinterface

// File: rtl/ram_march_bist.sv
// Three-pass March BIST for the register-file RAM: ascending fill, ascending
// read-and-invert, descending check; reports pass, first failure and error count.
module ram_march_bist #(
  parameter int MEM_SIZE  = 6,
  parameter int DATA_W    = 10,
  parameter int ADDR_SIZE = MEM_SIZE,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    pattern,
  ram_march_bist_if.master     ram,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  output logic [ERR_W-1:0]     err_count
);

  typedef enum logic [2:0] {IDLE, W_FILL, R_INV, R_CHK, DRAIN, DONE} state_e;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    pat_q;
  logic                 start_acc;

  logic                 write_c, read_c;
  logic [ADDR_SIZE-1:0] addr_w_c, addr_r_c;
  logic [DATA_W-1:0]    datain_c, exp_c;

  logic                 cmp_valid;
  logic [DATA_W-1:0]    cmp_exp;
  logic [ADDR_SIZE-1:0] cmp_addr;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (start_acc) pat_q <= pattern;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_c  = 1'b0;
    read_c   = 1'b0;
    addr_w_c = '0;
    addr_r_c = '0;
    datain_c = '0;
    exp_c    = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = W_FILL;
          addr_d  = '0;
        end
      end
      W_FILL: begin
        write_c  = 1'b1;
        addr_w_c = addr_q;
        datain_c = pat_q;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = R_INV;
        end else begin
          addr_d = addr_q + ADDR_SIZE'(1);
        end
      end
      R_INV: begin
        // Same-address read+write: the RAM returns the old word, i.e. the fill pattern.
        write_c  = 1'b1;
        read_c   = 1'b1;
        addr_w_c = addr_q;
        addr_r_c = addr_q;
        datain_c = ~pat_q;
        exp_c    = pat_q;
        if (addr_q == LAST_ADDR) begin
          state_d = R_CHK;
        end else begin
          addr_d = addr_q + ADDR_SIZE'(1);
        end
      end
      R_CHK: begin
        read_c   = 1'b1;
        addr_r_c = addr_q;
        exp_c    = ~pat_q;
        if (addr_q == '0) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q - ADDR_SIZE'(1);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign ram.write  = write_c;
  assign ram.read   = read_c;
  assign ram.addr_w = addr_w_c;
  assign ram.addr_r = addr_r_c;
  assign ram.datain = datain_c;

  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

  // Read data arrives one cycle after the strobe, so expectation and address
  // travel alongside it; a cleared valid keeps stale dataout out of the check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      cmp_valid <= read_c;
      cmp_exp   <= exp_c;
      cmp_addr  <= addr_r_c;
      if (start_acc) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (cmp_valid && (ram.dataout != cmp_exp)) begin
        if (err_count == '0) begin
          fail_addr <= cmp_addr;
          fail_data <= ram.dataout;
        end
        if (!(&err_count)) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Randomized scoreboard bench for ram_march_bist: a behavioural RAM with injectable
// faults, an abstract March model producing expected commands and results.
module tb_ram_march_bist;

  localparam int MEM_SIZE  = 6;
  localparam int DATA_W    = 10;
  localparam int ADDR_SIZE = MEM_SIZE;

  typedef enum int {F_NONE, F_STUCK, F_ALIAS, F_FORCE} fault_e;
  typedef struct {
    int                   err;
    logic [ADDR_SIZE-1:0] fa;
    logic [DATA_W-1:0]    fd;
  } result_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [DATA_W-1:0]    pattern = '0;
  logic                 busy, done, pass;
  logic [ADDR_SIZE-1:0] fail_addr;
  logic [DATA_W-1:0]    fail_data;
  logic [7:0]           err_count;
  logic                 s_busy, s_done, s_pass;
  logic [ADDR_SIZE-1:0] s_fail_addr;
  logic [DATA_W-1:0]    s_fail_data;
  logic [2:0]           s_err_count;

  ram_march_bist_if #(.DATA_W(DATA_W), .ADDR_SIZE(ADDR_SIZE)) ram_if ();
  ram_march_bist_if #(.DATA_W(DATA_W), .ADDR_SIZE(ADDR_SIZE)) sat_if ();

  ram_march_bist #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W), .ADDR_SIZE(ADDR_SIZE), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .ram(ram_if.master),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr),
    .fail_data(fail_data), .err_count(err_count)
  );

  // Narrow-counter twin sharing the same RAM read data, for saturation.
  ram_march_bist #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W), .ADDR_SIZE(ADDR_SIZE), .ERR_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .ram(sat_if.master),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail_addr(s_fail_addr),
    .fail_data(s_fail_data), .err_count(s_err_count)
  );

  assign sat_if.dataout = ram_if.dataout;

  always #5 clk = ~clk;

  fault_e            fault = F_NONE;
  logic [DATA_W-1:0] mem [MEM_SIZE] = '{default: '0};
  logic [DATA_W-1:0] snap [MEM_SIZE];
  logic [31:0]       cmd_q [$];
  result_t           res_q [$];
  int                n_vec  = 0;
  int                n_miss = 0;

  function automatic int wloc(input int a, input fault_e f);
    return (f == F_ALIAS && a == 4) ? 2 : a;
  endfunction

  function automatic logic [DATA_W-1:0] rval(input logic [DATA_W-1:0] v, input int a, input fault_e f);
    logic [DATA_W-1:0] r;
    r = v;
    if (f == F_STUCK && a == 3) r[0] = 1'b0;
    if (f == F_FORCE) r[0] = ~r[0];
    return r;
  endfunction

  // Behavioural RAM: registered read returning the old word, optional faults.
  int                ram_ra, ram_wa;
  always @(posedge clk) begin
    if (ram_if.read) begin
      ram_ra = int'(ram_if.addr_r);
      ram_if.dataout <= rval(mem[ram_ra], ram_ra, fault);
    end
    if (ram_if.write) begin
      ram_wa = wloc(int'(ram_if.addr_w), fault);
      mem[ram_wa] <= ram_if.datain;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void note(inout result_t r, input int a, input logic [DATA_W-1:0] got,
                               input logic [DATA_W-1:0] exp);
    if (got != exp) begin
      if (r.err == 0) begin
        r.fa = ADDR_SIZE'(a);
        r.fd = got;
      end
      r.err++;
    end
  endfunction

  // Abstract March run over a copy of the RAM contents.
  function automatic result_t model(input logic [DATA_W-1:0] p, input fault_e f);
    logic [DATA_W-1:0] m [MEM_SIZE];
    result_t r;
    r.err = 0;
    r.fa  = '0;
    r.fd  = '0;
    m = snap;
    for (int a = 0; a < MEM_SIZE; a++) m[wloc(a, f)] = p;
    for (int a = 0; a < MEM_SIZE; a++) begin
      note(r, a, rval(m[a], a, f), p);
      m[wloc(a, f)] = ~p;
    end
    for (int a = MEM_SIZE - 1; a >= 0; a--) note(r, a, rval(m[a], a, f), ~p);
    return r;
  endfunction

  function automatic logic [31:0] mk_cmd(input bit w, input bit r, input int aw, input int ar,
                                         input logic [DATA_W-1:0] d);
    return {8'h0, w, r, ADDR_SIZE'(aw), ADDR_SIZE'(ar), d};
  endfunction

  function automatic void push_cmds(input logic [DATA_W-1:0] p, input int limit);
    logic [31:0] seq [$];
    for (int a = 0; a < MEM_SIZE; a++) seq.push_back(mk_cmd(1'b1, 1'b0, a, 0, p));
    for (int a = 0; a < MEM_SIZE; a++) seq.push_back(mk_cmd(1'b1, 1'b1, a, a, ~p));
    for (int a = MEM_SIZE - 1; a >= 0; a--) seq.push_back(mk_cmd(1'b0, 1'b1, 0, a, '0));
    seq.push_back('0);
    for (int i = 0; i < limit && i < seq.size(); i++) cmd_q.push_back(seq[i]);
  endfunction

  // Monitor: retires one command per busy cycle and one result per rising done.
  initial begin
    logic    prev_done;
    result_t e;
    int      e8, e3;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (busy) begin
          check("cmd_avail", 32'(cmd_q.size() != 0), 32'd1);
          if (cmd_q.size() != 0)
            check("cmd", {8'h0, ram_if.write, ram_if.read, ram_if.addr_w, ram_if.addr_r, ram_if.datain},
                  cmd_q.pop_front());
        end
        if (done && !prev_done) begin
          check("cmd_left_at_done", cmd_q.size(), 0);
          check("res_avail", 32'(res_q.size() != 0), 32'd1);
          if (res_q.size() != 0) begin
            e  = res_q.pop_front();
            e8 = (e.err > 255) ? 255 : e.err;
            e3 = (e.err > 7) ? 7 : e.err;
            check("err_count", err_count, e8);
            check("fail_addr", fail_addr, e.fa);
            check("fail_data", fail_data, e.fd);
            check("pass", pass, 32'(e.err == 0));
            check("sat_err_count", s_err_count, e3);
            check("sat_fail_addr", s_fail_addr, e.fa);
            check("sat_done", s_done, 1);
          end
        end
        prev_done = done;
      end
    end
  end

  // Caller is 1 ns after a rising edge; start is sampled at the next edge (edge 0).
  task automatic run_test(input logic [DATA_W-1:0] p, input fault_e f, input bit glitch);
    int k;
    fault = f;
    snap  = mem;
    push_cmds(p, 1000);
    res_q.push_back(model(p, f));
    start   = 1'b1;
    pattern = p;
    @(posedge clk); #1;
    start   = 1'b0;
    pattern = DATA_W'($urandom);
    check("start_clears_err", err_count, 0);
    check("start_clears_done", done, 0);
    check("busy_after_start", busy, 1);
    k = 0;
    while (!done && k < 100) begin
      if (glitch && (k == 4 || k == 9)) begin
        start   = 1'b1;
        pattern = DATA_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("done_latency", k, 19);
    @(posedge clk); #1;
    check("done_hold", done, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_abort(input logic [DATA_W-1:0] p);
    fault = F_NONE;
    push_cmds(p, 8);
    start   = 1'b1;
    pattern = p;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_write", ram_if.write, 0);
    check("rst_read", ram_if.read, 0);
    check("rst_addr_w", ram_if.addr_w, 0);
    check("rst_addr_r", ram_if.addr_r, 0);
    check("rst_datain", ram_if.datain, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sat_busy", s_busy, 0);
    check("rst_cmds_consumed", cmd_q.size(), 0);
    cmd_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd", {ram_if.write, ram_if.read}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_count, 0);
    check("reset_fail_addr", fail_addr, 0);
    check("reset_fail_data", fail_data, 0);
    check("reset_write", ram_if.write, 0);
    check("reset_read", ram_if.read, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_test(10'h2A5, F_NONE, 1'b0);
    repeat (2) run_test(DATA_W'($urandom), F_NONE, 1'b0);
    run_test(DATA_W'($urandom), F_NONE, 1'b1);
    run_test(10'h001, F_STUCK, 1'b0);
    run_test(10'h0F0, F_ALIAS, 1'b0);
    run_abort(DATA_W'($urandom));
    run_test(DATA_W'($urandom), F_NONE, 1'b0);
    run_test(DATA_W'($urandom), F_FORCE, 1'b0);
    run_test(DATA_W'($urandom), F_NONE, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("cmd_q_drained", cmd_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator for the team's dual-port register-file RAM.
- Drives the RAM's write/read command interface (write, datain, addr_w, read, addr_r), captures the 1-cycle-latency registered dataout, and checks it against expected values.
- Runs a three-pass March sequence over every address and reports pass/fail, first-failure address/data and an error count.
- Sits between the test controller and the RAM; the RAM's ports connect 1:1.

Parameters:
- MEM_SIZE, 6, number of RAM words; tested addresses are 0..MEM_SIZE-1.
- DATA_W, 10, RAM data width.
- ADDR_SIZE, MEM_SIZE, RAM address width.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  1-cycle pulse; starts a test when idle or done.
- pattern  in  DATA_W  background pattern, sampled on the accepted start.
- write  out  1  RAM write strobe.
- datain  out  DATA_W  RAM write data.
- addr_w  out  ADDR_SIZE  RAM write address.
- read  out  1  RAM read strobe.
- addr_r  out  ADDR_SIZE  RAM read address.
- dataout  in  DATA_W  RAM registered read data.
- busy  out  1  test in progress.
- done  out  1  test finished; held until the next accepted start.
- pass  out  1  done && err_count==0.
- fail_addr  out  ADDR_SIZE  address of the first mismatch.
- fail_data  out  DATA_W  data read at the first mismatch.
- err_count  out  ERR_W  mismatches, saturating at all-ones.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - write, read, busy, done, pass, err_count, fail_addr, fail_data = 0.
  - Compare pipeline cleared.
- States: IDLE, W_FILL, R_INV, R_CHK, DRAIN, DONE.
- start is accepted only in IDLE or DONE and ignored while busy.
- On the accepted edge:
  - Latch pattern into P.
  - Clear err_count, fail_*, done.
  - addr=0, go to W_FILL.
- W_FILL (ascending):
  - write=1, read=0, addr_w=addr, datain=P.
  - At addr==MEM_SIZE-1: addr=0, go to R_INV.
- R_INV (ascending):
  - write=1, read=1, addr_r=addr_w=addr, datain=~P, expected=P.
  - The RAM returns old contents on a same-address read+write.
  - At addr==MEM_SIZE-1: addr=MEM_SIZE-1, go to R_CHK.
- R_CHK (descending):
  - write=0, read=1, addr_r=addr, expected=~P.
  - At addr==0: go to DRAIN.
- DRAIN: write=read=0 for one cycle; the final read's data is compared here.
- DONE:
  - done=1, busy=0, write=read=0.
  - Results held stable until the next start or rst.
- Command outputs decode combinationally from state/addr registers.
- In IDLE and DONE, write=read=0 and addresses/datain are 0.
- Comparison:
  - Each cycle with read=1 loads a valid bit, the expected value and addr_r into a 1-stage pipeline.
  - In the next cycle, if valid, compare dataout against expected.
  - dataout is ignored when valid=0. The RAM then holds last-read data, which must not be checked.
- On mismatch:
  - err_count increments, saturating.
  - If err_count was 0, fail_addr/fail_data capture the pipelined address and dataout.
- Timing, with N=MEM_SIZE and start accepted at edge 0:
  - W_FILL at edges 1..N.
  - R_INV at edges N+1..2N.
  - R_CHK at edges 2N+1..3N.
  - DRAIN, then done=1 after edge 3N+1.
  - For N=6, done rises 19 edges after start.
- busy=1 from the accepted start edge until the edge that sets done.
- Address counter width is ADDR_SIZE. Wrap occurs at MEM_SIZE-1, never at 2^ADDR_SIZE-1.
- rst mid-test aborts immediately. No RAM command is issued in the cycle after rst.

Test Plan:
- Healthy RAM model, N=6, pattern=10'h2A5, start at cycle 0:
  - busy for 19 edges.
  - done=1, pass=1, err_count=0.
  - 6 writes of 2A5, then 6 read+writes of 15A, then 6 reads at addresses 5..0.
- Stuck-at-0 on bit 0 at address 3, pattern=10'h001:
  - R_INV mismatch at address 3, read 000.
  - R_CHK reads 3FE, matching expected.
  - err_count=1, fail_addr=3, fail_data=10'h000, pass=0.
- Address alias (address 4 writes land in 2), pattern=10'h0F0:
  - At least 1 error.
  - fail_addr is the first mismatching address in sequence order.
- start pulsed at edges 5 and 10 during the run: both ignored, and done still arrives after edge 19.
- rst asserted asynchronously mid-R_INV:
  - All outputs are 0 immediately.
  - A following start runs the full test, pass=1.
- Forced persistent mismatch on every read with ERR_W=3:
  - 12 mismatches; err_count saturates at 7.
  - fail_addr=0 (first R_INV read).
  - A new start clears the results.
